// File: rtl/rec_pkg.sv
// Shared definitions for the receive-channel scheduler and switch.
package rec_pkg;

  localparam logic [2:0] CH_PARKED  = 3'd7;
  localparam int         REC_NUM_CH = 6;
  localparam int         REC_USDW_W = 8;
  localparam int         REC_CH_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_XFER   = 3'd3,
    S_DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rec_channel_scheduler_if.sv
// Control/status bundle between the scheduler, the FIFO status, the switch and the DMA master.
interface rec_channel_scheduler_if #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3,
  parameter int USDW_W = 8
);
  logic                       enable;
  logic [NUM_CH-1:0]          ch_mask;
  logic [USDW_W-1:0]          burst_words;
  logic [NUM_CH*USDW_W-1:0]   ch_usdw;
  logic                       dma_rd_req;
  logic [CH_W-1:0]            active_channel;
  logic                       dma_start;
  logic [USDW_W-1:0]          dma_len;
  logic                       burst_done;
  logic                       busy;
  logic                       stray_rd;

  modport master (
    output enable, ch_mask, burst_words, ch_usdw, dma_rd_req,
    input  active_channel, dma_start, dma_len, burst_done, busy, stray_rd
  );

  modport slave (
    input  enable, ch_mask, burst_words, ch_usdw, dma_rd_req,
    output active_channel, dma_start, dma_len, burst_done, busy, stray_rd
  );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority search: first eligible channel above last_ch, wrapping, last_ch itself checked last.
module rr_pick #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3
) (
  input  logic [NUM_CH-1:0] i_elig,
  input  logic [CH_W-1:0]   i_last_ch,
  output logic              o_grant_valid,
  output logic [CH_W-1:0]   o_grant_idx
);

  int w_idx;

  // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = (int'(i_last_ch) + k) % NUM_CH;
      if (i_elig[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = CH_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/rec_channel_scheduler.sv
// Round-robin burst scheduler: grants a FIFO channel to the switch, launches a DMA burst
// and counts read strobes until the burst completes.
module rec_channel_scheduler
  import rec_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int CH_W       = 3,
  parameter int USDW_W     = 8,
  parameter int SETTLE_CYC = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  rec_channel_scheduler_if.slave bus
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  sched_state_t      r_state;
  sched_state_t      w_next;
  logic [CH_W-1:0]   r_active;
  logic [CH_W-1:0]   r_last_ch;
  logic [USDW_W-1:0] r_dma_len;
  logic [USDW_W-1:0] r_word_cnt;
  logic [SET_W-1:0]  r_settle;
  logic              r_stray;
  logic [NUM_CH-1:0] w_elig;
  logic              w_grant_valid;
  logic [CH_W-1:0]   w_grant_idx;
  logic              w_grant;
  logic              w_last_word;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = bus.ch_mask[i] && (bus.burst_words != '0) &&
                  (bus.ch_usdw[i*USDW_W +: USDW_W] >= bus.burst_words);
    end
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .i_elig        (w_elig),
    .i_last_ch     (r_last_ch),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_grant     = bus.enable && w_grant_valid;
  assign w_last_word = bus.dma_rd_req && (r_word_cnt == r_dma_len - USDW_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_SETTLE;
      S_SETTLE: if (r_settle == '0) w_next = S_START;
      S_START:  w_next = S_XFER;
      S_XFER:   if (w_last_word) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dma_start  = (r_state == S_START);
    bus.burst_done = (r_state == S_DONE);
    bus.busy       = (r_state != S_IDLE);
  end

  // Grant inputs are sampled only in IDLE, so mask/length changes never touch a running burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active   <= CH_W'(CH_PARKED);
      r_last_ch  <= CH_W'(NUM_CH - 1);
      r_dma_len  <= '0;
      r_word_cnt <= '0;
      r_settle   <= '0;
      r_stray    <= 1'b0;
    end else begin
      if (bus.dma_rd_req && (r_state != S_XFER)) r_stray <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_active  <= w_grant_idx;
            r_dma_len <= bus.burst_words;
            r_settle  <= SET_W'(SETTLE_CYC - 1);
          end
        end
        S_SETTLE: if (r_settle != '0) r_settle <= r_settle - SET_W'(1);
        S_START:  r_word_cnt <= '0;
        S_XFER:   if (bus.dma_rd_req) r_word_cnt <= r_word_cnt + USDW_W'(1);
        S_DONE: begin
          r_last_ch <= r_active;
          r_active  <= CH_W'(CH_PARKED);
        end
        default: ;
      endcase
    end
  end

  assign bus.active_channel = r_active;
  assign bus.dma_len        = r_dma_len;
  assign bus.stray_rd       = r_stray;

endmodule

// File: tb/tb_rec_channel_scheduler.sv
// Self-checking bench for rec_channel_scheduler: vector table plus hand-written burst sequences.
module tb_rec_channel_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef logic [7:0] usdw_t [6];
  typedef struct { int ch; int len; } exp_t;
  typedef struct {
    logic [5:0] mask;
    logic [7:0] bw;
    usdw_t      u;
    bit         valid;
    int         ch;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [9];

  rec_channel_scheduler_if #(.NUM_CH(6), .CH_W(3), .USDW_W(8)) dut_if ();

  rec_channel_scheduler #(
    .NUM_CH(6), .CH_W(3), .USDW_W(8), .SETTLE_CYC(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dut_if)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic put_vec(input int i, input logic [5:0] m, input logic [7:0] bw,
                         input usdw_t u, input bit valid, input int ch);
    vecs[i].mask  = m;
    vecs[i].bw    = bw;
    vecs[i].u     = u;
    vecs[i].valid = valid;
    vecs[i].ch    = ch;
  endtask

  task automatic set_usdw(input usdw_t u);
    for (int i = 0; i < 6; i++) dut_if.ch_usdw[i*8 +: 8] = u[i];
  endtask

  task automatic do_reset();
    dut_if.enable     = 1'b0;
    dut_if.dma_rd_req = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_active"},     int'(dut_if.active_channel), 7);
    chk({tag, "_dma_start"},  int'(dut_if.dma_start), 0);
    chk({tag, "_dma_len"},    int'(dut_if.dma_len), 0);
    chk({tag, "_burst_done"}, int'(dut_if.burst_done), 0);
    chk({tag, "_busy"},       int'(dut_if.busy), 0);
    chk({tag, "_stray"},      int'(dut_if.stray_rd), 0);
  endtask

  // Waits for dma_start, pops the expected grant, then strobes n words.
  // drop_at > 0 drops enable and disturbs mask/length at that strobe.
  task automatic run_burst(input int n, input int drop_at, input int lat_exp);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (dut_if.dma_start) got = 1'b1;
    end
    chk("start_seen", int'(got), 1);
    if (!got) return;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("grant_ch", int'(dut_if.active_channel), e.ch);
    chk("dma_len_at_start", int'(dut_if.dma_len), e.len);
    chk("busy_at_start", int'(dut_if.busy), 1);
    if (lat_exp > 0) chk("start_latency", lat, lat_exp);
    @(negedge clk);
    chk("start_one_cycle", int'(dut_if.dma_start), 0);
    for (int k = 1; k <= n; k++) begin
      dut_if.dma_rd_req = 1'b1;
      if (k == drop_at) begin
        dut_if.enable      = 1'b0;
        dut_if.burst_words = 8'd3;
        dut_if.ch_mask     = 6'h00;
      end
      @(negedge clk);
      if (k < n) chk("no_early_done", int'(dut_if.burst_done), 0);
    end
    dut_if.dma_rd_req = 1'b0;
    chk("burst_done", int'(dut_if.burst_done), 1);
    chk("active_in_done", int'(dut_if.active_channel), e.ch);
    chk("dma_len_held", int'(dut_if.dma_len), e.len);
    @(negedge clk);
    chk("done_one_cycle", int'(dut_if.burst_done), 0);
    chk("parked_after", int'(dut_if.active_channel), 7);
    chk("no_stray", int'(dut_if.stray_rd), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    dut_if.enable      = 1'b0;
    dut_if.ch_mask     = '0;
    dut_if.burst_words = '0;
    dut_if.ch_usdw     = '0;
    dut_if.dma_rd_req  = 1'b0;

    put_vec(0, 6'h3F, 8'd16,  '{8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},       1'b1, 0);
    put_vec(1, 6'h3F, 8'd32,  '{8'd0, 8'd40, 8'd0, 8'd40, 8'd0, 8'd40},     1'b1, 1);
    put_vec(2, 6'h3F, 8'd0,   '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 1'b0, 0);
    put_vec(3, 6'h00, 8'd16,  '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 1'b0, 0);
    put_vec(4, 6'h3F, 8'd1,   '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0},        1'b1, 2);
    put_vec(5, 6'h3E, 8'd10,  '{8'd50, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0},      1'b1, 4);
    put_vec(6, 6'h3F, 8'd10,  '{8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0},        1'b0, 0);
    put_vec(7, 6'h3F, 8'd255, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255},      1'b1, 5);
    put_vec(8, 6'h1F, 8'd8,   '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200},      1'b0, 0);

    do_reset();
    check_reset_vals("por");

    for (int v = 0; v < 9; v++) begin
      do_reset();
      dut_if.ch_mask     = vecs[v].mask;
      dut_if.burst_words = vecs[v].bw;
      set_usdw(vecs[v].u);
      dut_if.enable      = 1'b1;
      if (vecs[v].valid) begin
        sb.push_back('{vecs[v].ch, int'(vecs[v].bw)});
        run_burst(int'(vecs[v].bw), 0, 3);
        dut_if.enable = 1'b0;
      end else begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          chk("nogrant_busy", int'(dut_if.busy), 0);
          chk("nogrant_active", int'(dut_if.active_channel), 7);
          chk("nogrant_start", int'(dut_if.dma_start), 0);
        end
        dut_if.enable = 1'b0;
      end
    end

    // Round robin over channels 1, 3, 5 with the pointer wrapping back to 1.
    do_reset();
    dut_if.ch_mask     = 6'h3F;
    dut_if.burst_words = 8'd32;
    set_usdw('{8'd0, 8'd40, 8'd0, 8'd40, 8'd0, 8'd40});
    sb.push_back('{1, 32});
    sb.push_back('{3, 32});
    sb.push_back('{5, 32});
    sb.push_back('{1, 32});
    dut_if.enable = 1'b1;
    for (int b = 0; b < 4; b++) run_burst(32, 0, 3);
    dut_if.enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_idle_busy", int'(dut_if.busy), 0);

    // Enable drop mid-burst, with mask/length disturbed: burst still runs its latched 16 words.
    do_reset();
    dut_if.ch_mask     = 6'h3F;
    dut_if.burst_words = 8'd16;
    set_usdw('{8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    sb.push_back('{0, 16});
    dut_if.enable = 1'b1;
    run_burst(16, 5, 3);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("disabled_busy", int'(dut_if.busy), 0);
      chk("disabled_active", int'(dut_if.active_channel), 7);
    end
    dut_if.ch_mask     = 6'h3F;
    dut_if.burst_words = 8'd16;
    sb.push_back('{0, 16});
    dut_if.enable = 1'b1;
    run_burst(16, 0, 3);
    dut_if.enable = 1'b0;

    // Stray strobe in IDLE is sticky; reset mid-XFER clears everything.
    do_reset();
    dut_if.dma_rd_req = 1'b1;
    @(negedge clk);
    dut_if.dma_rd_req = 1'b0;
    chk("stray_set", int'(dut_if.stray_rd), 1);
    chk("stray_busy", int'(dut_if.busy), 0);
    repeat (4) @(negedge clk);
    chk("stray_held", int'(dut_if.stray_rd), 1);
    dut_if.ch_mask     = 6'h3F;
    dut_if.burst_words = 8'd16;
    set_usdw('{8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    dut_if.enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seq_start", int'(dut_if.dma_start), 1);
    chk("rst_seq_active", int'(dut_if.active_channel), 0);
    @(negedge clk);
    dut_if.dma_rd_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seq_busy", int'(dut_if.busy), 1);
    chk("rst_seq_stray", int'(dut_if.stray_rd), 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midxfer");
    dut_if.dma_rd_req = 1'b0;
    dut_if.enable     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
